// File: rtl/riscv_mtimer.sv
// riscv_mtimer: memory-mapped RISC-V machine timer.
//   - 64-bit mtime counter advanced once per microsecond by a CLKFREQMHZ prescaler
//   - 64-bit mtimecmp compare register, reset to all-ones so the timer starts quiet
//   - registered level interrupt irq = (mtime >= mtimecmp)
//   - four 32-bit words: 0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi
//   - combinational zero-latency read path
// Optional build macro MTIMER_READ_LATCH_EN: a read of word 0 snapshots
// mtime[63:32] so that a following read of word 1 is coherent across a carry.
module riscv_mtimer #(
  parameter int unsigned CLKFREQMHZ = 100  // legal 1..1023
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam int unsigned     PW      = 10;
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLKFREQMHZ - 1);

  localparam logic [1:0] ADDR_MTIME_LO = 2'd0;
  localparam logic [1:0] ADDR_MTIME_HI = 2'd1;
  localparam logic [1:0] ADDR_CMP_LO   = 2'd2;
  localparam logic [1:0] ADDR_CMP_HI   = 2'd3;

  logic [PW-1:0] pre_q, pre_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          irq_q, irq_d;
  logic          tick;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   mtime_hi_rd;

  // Bus qualification: a read is only a read when no write shares the cycle.
  assign wr_en = cs & wr;
  assign rd_en = cs & rd & ~wr;

  // Prescaler: count 0..CLKFREQMHZ-1, tick on the last count and wrap.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // mtime next state: a software write to either half beats the tick, and
  // the untouched half holds (no carry into or out of a written word).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mtime_d = mtime_q;
    if (wr_en && addr == ADDR_MTIME_LO) begin
      mtime_d[31:0] = wdata;
    end else if (wr_en && addr == ADDR_MTIME_HI) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtimecmp next state: plain half-word writes.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && addr == ADDR_CMP_LO) begin
      mtimecmp_d[31:0] = wdata;
    end else if (wr_en && addr == ADDR_CMP_HI) begin
      mtimecmp_d[63:32] = wdata;
    end
  end

  // Interrupt compares the values this edge is about to load.
  assign irq_d = (mtime_d >= mtimecmp_d);

  // Timer state registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pre_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      pre_q      <= pre_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

`ifdef MTIMER_READ_LATCH_EN
  logic [31:0] shadow_q, shadow_d;

  // Shadow of mtime[63:32]: captured on a word-0 read, replaced by a word-1 write.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_en && addr == ADDR_MTIME_LO) begin
      shadow_d = mtime_q[63:32];
    end else if (wr_en && addr == ADDR_MTIME_HI) begin
      shadow_d = wdata;
    end
  end

  // Shadow register; it is a single control word, so it is reset like the rest.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  // Combinational read mux; drives zero whenever no qualified read is present.
  always_comb begin
    rdata  = '0;
    rvalid = rd_en;
    if (rd_en) begin
      case (addr)
        ADDR_MTIME_LO: rdata = mtime_q[31:0];
        ADDR_MTIME_HI: rdata = mtime_hi_rd;
        ADDR_CMP_LO:   rdata = mtimecmp_q[31:0];
        default:       rdata = mtimecmp_q[63:32];
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_riscv_mtimer.sv
// Self-checking bench for riscv_mtimer.
// Directed steps follow the timer's documented behaviour, then a randomized
// bus phase is checked against a cycle-level behavioural model of the timer.
// A second instance with CLKFREQMHZ = 1 checks the tick-every-cycle case.
module tb_riscv_mtimer;

  localparam int unsigned F = 100;

  logic        clk    = 1'b0;
  logic        nreset = 1'b0;
  logic        cs     = 1'b0;
  logic        wr     = 1'b0;
  logic        rd     = 1'b0;
  logic [1:0]  addr   = 2'd0;
  logic [31:0] wdata  = 32'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  logic [31:0] rdata1;
  logic        rvalid1;
  logic        irq1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: time in microseconds, compare value, phase within
  // the current microsecond, read shadow and expected interrupt level.
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  int unsigned m_phase;
  logic [31:0] m_shadow;
  logic        m_irq;

  riscv_mtimer #(.CLKFREQMHZ(F)) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .cs     (cs),
    .addr   (addr),
    .wr     (wr),
    .wdata  (wdata),
    .rd     (rd),
    .rdata  (rdata),
    .rvalid (rvalid),
    .irq    (irq)
  );

  riscv_mtimer #(.CLKFREQMHZ(1)) u_dut1 (
    .clk    (clk),
    .nreset (nreset),
    .cs     (1'b1),
    .addr   (2'd0),
    .wr     (1'b0),
    .wdata  (32'd0),
    .rd     (1'b1),
    .rdata  (rdata1),
    .rvalid (rvalid1),
    .irq    (irq1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the bus inputs now applied.
  function automatic void model_edge();
    logic        is_tick = (m_phase == F - 1);
    logic        we      = cs & wr;
    logic        re      = cs & rd & ~wr;
    logic [63:0] t       = m_time;
    logic [63:0] c       = m_cmp;
    m_phase = is_tick ? 0 : m_phase + 1;
    if (we && addr == 2'd0)      t = {m_time[63:32], wdata};
    else if (we && addr == 2'd1) t = {wdata, m_time[31:0]};
    else if (is_tick)            t = m_time + 64'd1;
    if (we && addr == 2'd2)      c = {m_cmp[63:32], wdata};
    if (we && addr == 2'd3)      c = {wdata, m_cmp[31:0]};
`ifdef MTIMER_READ_LATCH_EN
    if (re && addr == 2'd0)      m_shadow = m_time[63:32];
    else if (we && addr == 2'd1) m_shadow = wdata;
`else
    if (re) m_shadow = m_shadow;
`endif
    m_time = t;
    m_cmp  = c;
    m_irq  = (t >= c);
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!(cs && rd && !wr)) return 32'd0;
    case (addr)
      2'd0:    return m_time[31:0];
`ifdef MTIMER_READ_LATCH_EN
      2'd1:    return m_shadow;
`else
      2'd1:    return m_time[63:32];
`endif
      2'd2:    return m_cmp[31:0];
      default: return m_cmp[63:32];
    endcase
  endfunction

  task automatic set_bus(input logic c, input logic w, input logic r,
                         input logic [1:0] a, input logic [31:0] d);
    cs = c; wr = w; rd = r; addr = a; wdata = d;
  endtask

  // One clock: model follows the edge, irq checked on the following falling edge.
  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("irq", {63'd0, irq}, {63'd0, m_irq});
  endtask

  task automatic idle(input int n);
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (n) tick_clk();
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    set_bus(1'b1, 1'b1, 1'b0, a, d);
    tick_clk();
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    set_bus(1'b1, 1'b0, 1'b1, a, 32'd0);
    #1;
    check("rvalid", {63'd0, rvalid}, 64'd1);
    check("rdata_model", {32'd0, rdata}, {32'd0, exp_rdata()});
    v = rdata;
    tick_clk();
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] hi;
    logic        found;

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_rdata_idle", {32'd0, rdata}, 64'd0);
    check("rst_rvalid_idle", {63'd0, rvalid}, 64'd0);
    set_bus(1'b1, 1'b0, 1'b1, 2'd2, 32'd0);
    #1;
    check("rst_cmp_lo", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFF);
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    m_time   = 64'd0;
    m_cmp    = '1;
    m_phase  = 0;
    m_shadow = 32'd0;
    m_irq    = 1'b0;
    @(negedge clk);
    nreset = 1'b1;

    // ---- idle counting ----
    idle(100);
    check("f1_count100", {32'd0, rdata1}, 64'd100);
    read_reg(2'd0, v);
    check("idle_100", {32'd0, v}, 64'd1);
    idle(899);
    check("f1_count1000", {32'd0, rdata1}, 64'd1000);
    read_reg(2'd0, v);
    check("idle_1000", {32'd0, v}, 64'd10);
    read_reg(2'd2, v);
    check("cmp_lo_reset", {32'd0, v}, 64'hFFFF_FFFF);
    read_reg(2'd3, v);
    check("cmp_hi_reset", {32'd0, v}, 64'hFFFF_FFFF);
    check("irq_idle", {63'd0, irq}, 64'd0);

    // ---- low-to-high carry ----
    write_reg(2'd0, 32'hFFFF_FFFE);
    write_reg(2'd1, 32'd0);
    idle(2 * F);
    read_reg(2'd0, v);
    check("carry_lo", {32'd0, v}, 64'd0);
    read_reg(2'd1, v);
    check("carry_hi", {32'd0, v}, 64'd1);

    // ---- interrupt rise and clear ----
    write_reg(2'd1, 32'd0);
    write_reg(2'd0, 32'd0);
    write_reg(2'd3, 32'd0);
    write_reg(2'd2, 32'd5);
    found = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 8 * F; i++) begin
      if (m_time == 64'd5) begin
        found = 1'b1;
        break;
      end
      tick_clk();
    end
    check("irq_wait_reach5", {63'd0, found}, 64'd1);
    check("irq_at_5", {63'd0, irq}, 64'd1);
    write_reg(2'd2, 32'h10);
    check("irq_drop", {63'd0, irq}, 64'd0);

    // ---- write on the tick cycle ----
    for (int i = 0; i < F; i++) begin
      if (m_phase == F - 1) break;
      idle(1);
    end
    check("tick_align", m_phase, F - 1);
    hi = m_time[63:32];
    write_reg(2'd0, 32'h100);
    read_reg(2'd0, v);
    check("tick_write_lo", {32'd0, v}, 64'h100);
    read_reg(2'd1, v);
    check("tick_write_hi", {32'd0, v}, {32'd0, hi});

    // ---- unselected accesses and read+write collision ----
    set_bus(1'b0, 1'b0, 1'b1, 2'd0, 32'd0);
    #1;
    check("nocs_rdata", {32'd0, rdata}, 64'd0);
    check("nocs_rvalid", {63'd0, rvalid}, 64'd0);
    tick_clk();
    set_bus(1'b0, 1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF);
    tick_clk();
    read_reg(2'd2, v);
    check("nocs_write_ignored", {32'd0, v}, 64'h10);
    set_bus(1'b1, 1'b1, 1'b1, 2'd3, 32'd1);
    #1;
    check("rdwr_rdata", {32'd0, rdata}, 64'd0);
    check("rdwr_rvalid", {63'd0, rvalid}, 64'd0);
    tick_clk();
    read_reg(2'd3, v);
    check("rdwr_write_done", {32'd0, v}, 64'd1);

    // ---- coherent high-word read ----
    write_reg(2'd1, 32'd0);
    write_reg(2'd0, 32'hFFFF_FFFF);
    read_reg(2'd0, v);
    check("latch_lo", {32'd0, v}, 64'hFFFF_FFFF);
    idle(F);
    read_reg(2'd1, v);
`ifdef MTIMER_READ_LATCH_EN
    check("latch_hi_shadow", {32'd0, v}, 64'd0);
`else
    check("latch_hi_live", {32'd0, v}, 64'd1);
`endif

    // ---- randomized bus traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      logic        c = ($urandom % 4) != 0;
      logic        w = ($urandom % 4) == 0;
      logic        r = ($urandom % 2) != 0;
      logic [1:0]  a = 2'($urandom % 4);
      logic [31:0] d = ($urandom % 2) != 0 ? $urandom : ($urandom % 8);
      set_bus(c, w, r, a, d);
      #1;
      check("rnd_rvalid", {63'd0, rvalid}, {63'd0, c & r & ~w});
      check("rnd_rdata", {32'd0, rdata}, {32'd0, exp_rdata()});
      tick_clk();
    end
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
